// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - CPU-programmed SPI mode-0 master with 4-deep TX FIFO and RX store (optional RX FIFO via SPIM_RXFIFO_EN)
module spi_master_ctrl (
    input  logic       clk6x,
    input  logic       reset,
    input  logic       reg_sel_i,
    input  logic       rd_trigger_i,
    input  logic       wr_trigger_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o,
    output logic       spi_sck_o,
    output logic       spi_mosi_o,
    input  logic       spi_miso_i,
    output logic [1:0] spi_csn_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_next;

    // CPU access decode
    logic ctrl_wr;
    logic data_wr;
    logic data_rd;
    logic tx_clr;
    logic rx_clr;
    logic new_target_ok;
    logic target_ok;
    logic abort;

    // control register
    logic [2:0] target;
    logic [2:0] speed;

    // TX FIFO
    logic [7:0] tx_mem [4];
    logic [1:0] tx_rd_ptr;
    logic [1:0] tx_wr_ptr;
    logic [2:0] tx_count;
    logic       tx_full;
    logic       tx_ne;
    logic       tx_push;
    logic       tx_pop;

    // shifter datapath
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic [2:0] bit_idx;
    logic [2:0] cur_speed;
    logic [6:0] half_cnt;
    logic [7:0] half_len;
    logic       half_last;
    logic       half_clr;
    logic       sample_miso;
    logic       next_bit;
    logic       rx_push;

    // RX store
    logic       rx_ne;
    logic       rx_pop;
    logic [7:0] rx_head;
    logic       overflow;
    logic [7:0] status;

    assign ctrl_wr       = wr_trigger_i && !reg_sel_i;
    assign data_wr       = wr_trigger_i && reg_sel_i;
    assign data_rd       = rd_trigger_i && reg_sel_i;
    assign tx_clr        = ctrl_wr && wdata_i[6];
    assign rx_clr        = ctrl_wr && wdata_i[7];
    assign new_target_ok = (wdata_i[2:0] == 3'd1) || (wdata_i[2:0] == 3'd2);
    assign target_ok     = (target == 3'd1) || (target == 3'd2);
    // A deselecting CTRL write kills any transfer in flight and blocks a same-cycle start
    assign abort         = ctrl_wr && !new_target_ok;

    assign tx_full = (tx_count == 3'd4);
    assign tx_ne   = (tx_count != 3'd0);
    assign tx_push = data_wr && !tx_full;

    assign half_len  = 8'd1 << cur_speed;
    assign half_last = ({1'b0, half_cnt} == (half_len - 8'd1));

    assign status = {(state != ST_IDLE) || tx_ne, rx_ne, tx_full, overflow, 1'b0, target};

    // chip selects decode straight from the target field
    always_comb begin
        case (target)
            3'd1:    spi_csn_o = 2'b10;
            3'd2:    spi_csn_o = 2'b01;
            default: spi_csn_o = 2'b11;
        endcase
    end

    // read mux: status on CTRL, RX head (or zero when empty) on DATA
    always_comb begin
        rdata_o = 8'h00;
        if (rd_trigger_i) begin
            if (!reg_sel_i) begin
                rdata_o = status;
            end else if (rx_ne) begin
                rdata_o = rx_head;
            end
        end
    end

    // control register fields
    always_ff @(posedge clk6x) begin
        if (reset) begin
            target <= 3'd0;
            speed  <= 3'd0;
        end else if (ctrl_wr) begin
            target <= wdata_i[2:0];
            speed  <= wdata_i[5:3];
        end
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk6x) begin
        if (reset || tx_clr) begin
            tx_rd_ptr <= 2'd0;
            tx_wr_ptr <= 2'd0;
            tx_count  <= 3'd0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 2'd1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 2'd1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 3'd1;
                2'b01:   tx_count <= tx_count - 3'd1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    // TX FIFO storage
    always_ff @(posedge clk6x) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= wdata_i;
    end

    // shifter state register
    always_ff @(posedge clk6x) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // shifter next-state and pin/strobe decode
    always_comb begin
        state_next  = state;
        tx_pop      = 1'b0;
        rx_push     = 1'b0;
        sample_miso = 1'b0;
        next_bit    = 1'b0;
        half_clr    = 1'b0;
        spi_sck_o   = 1'b0;
        spi_mosi_o  = 1'b1;
        case (state)
            ST_IDLE: begin
                if (tx_ne && target_ok && !abort) begin
                    state_next = ST_LOW;
                    tx_pop     = 1'b1;
                    half_clr   = 1'b1;
                end
            end
            ST_LOW: begin
                spi_mosi_o = tx_shift[bit_idx];
                if (half_last) begin
                    state_next  = ST_HIGH;
                    sample_miso = 1'b1;
                    half_clr    = 1'b1;
                end
            end
            ST_HIGH: begin
                spi_sck_o  = 1'b1;
                spi_mosi_o = tx_shift[bit_idx];
                if (half_last) begin
                    half_clr = 1'b1;
                    if (bit_idx == 3'd0) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_LOW;
                        next_bit   = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                spi_mosi_o = tx_shift[0];
                rx_push    = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (abort) begin
            state_next  = ST_IDLE;
            rx_push     = 1'b0;
            sample_miso = 1'b0;
            next_bit    = 1'b0;
        end
    end

    // shift registers, bit index and half-period timer; speed is frozen per byte
    always_ff @(posedge clk6x) begin
        if (reset) begin
            tx_shift  <= 8'h00;
            rx_shift  <= 8'h00;
            bit_idx   <= 3'd7;
            cur_speed <= 3'd0;
            half_cnt  <= 7'd0;
        end else begin
            if (tx_pop) begin
                tx_shift  <= tx_mem[tx_rd_ptr];
                bit_idx   <= 3'd7;
                cur_speed <= speed;
            end else if (next_bit) begin
                bit_idx <= bit_idx - 3'd1;
            end
            if (sample_miso) rx_shift <= {rx_shift[6:0], spi_miso_i};
            if (half_clr || state == ST_IDLE) half_cnt <= 7'd0;
            else                              half_cnt <= half_cnt + 7'd1;
        end
    end

`ifdef SPIM_RXFIFO_EN
    logic [7:0] rx_mem [4];
    logic [1:0] rx_rd_ptr;
    logic [1:0] rx_wr_ptr;
    logic [2:0] rx_count;
    logic       rx_accept;

    assign rx_ne     = (rx_count != 3'd0);
    assign rx_pop    = data_rd && rx_ne;
    assign rx_head   = rx_mem[rx_rd_ptr];
    // a pop in the same cycle frees the slot the incoming byte needs
    assign rx_accept = rx_push && ((rx_count != 3'd4) || rx_pop);

    // RX FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk6x) begin
        if (reset || rx_clr) begin
            rx_rd_ptr <= 2'd0;
            rx_wr_ptr <= 2'd0;
            rx_count  <= 3'd0;
            overflow  <= 1'b0;
        end else begin
            if (rx_accept) rx_wr_ptr <= rx_wr_ptr + 2'd1;
            if (rx_pop)    rx_rd_ptr <= rx_rd_ptr + 2'd1;
            case ({rx_accept, rx_pop})
                2'b10:   rx_count <= rx_count + 3'd1;
                2'b01:   rx_count <= rx_count - 3'd1;
                default: rx_count <= rx_count;
            endcase
            if (rx_push && !rx_accept) overflow <= 1'b1;
        end
    end

    // RX FIFO storage
    always_ff @(posedge clk6x) begin
        if (rx_accept) rx_mem[rx_wr_ptr] <= rx_shift;
    end
`else
    logic [7:0] rx_hold;
    logic       rx_valid;

    assign rx_ne   = rx_valid;
    assign rx_pop  = data_rd && rx_valid;
    assign rx_head = rx_hold;

    // single holding register: newest byte always wins, unread data flags overflow
    always_ff @(posedge clk6x) begin
        if (reset || rx_clr) begin
            rx_hold  <= 8'h00;
            rx_valid <= 1'b0;
            overflow <= 1'b0;
        end else if (rx_push) begin
            rx_hold  <= rx_shift;
            rx_valid <= 1'b1;
            if (rx_valid && !rx_pop) overflow <= 1'b1;
        end else if (rx_pop) begin
            rx_valid <= 1'b0;
        end
    end
`endif

endmodule
